// File: rtl/mips_multicycle_controller_if.sv
// Memory-port handshake between the multicycle controller (master) and the memory system (slave).
interface mips_multicycle_controller_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_waitrequest;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_waitrequest);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_waitrequest);
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM with wait-request memory handshake, timeout fault and PC-0 halt.
// Optional feature macro MULDIV_STALL_EN: start/busy handshake with an iterative mult/div unit.
module mips_multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  mips_multicycle_controller_if.master mem,
  input  logic [31:0] instruction,
  input  logic        pc_zero,
  input  logic        alu_zero,
  input  logic        rs_sign,
  input  logic        rs_zero,
`ifdef MULDIV_STALL_EN
  input  logic        muldiv_busy,
  output logic        muldiv_start,
`endif
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        register_write,
  output logic        memory_to_register,
  output logic        hi_lo_register_write,
  output logic [1:0]  register_destination,
  output logic        ALU_src_A,
  output logic [1:0]  ALU_src_B,
  output logic [5:0]  ALU_function,
  output logic        active,
  output logic        fault
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam bit                   L_TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] L_WAIT_LAST  = TIMEOUT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_wait_cnt;

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic [4:0] w_rt;
  logic       w_unused;
  logic       w_is_rtype, w_is_jr, w_is_muldiv, w_is_mfhilo, w_is_branch;
  logic       w_is_j, w_is_jal, w_is_load, w_is_store, w_legal, w_br_cond;
  logic [5:0] w_alu_func;
  logic [1:0] w_alu_src_b;
  logic       w_timeout;
  state_t     w_ex_next;
  logic       w_mem_read, w_mem_write, w_i_or_d;

  assign w_opcode  = instruction[31:26];
  assign w_funct   = instruction[5:0];
  assign w_rt      = instruction[20:16];
  assign w_unused  = ^{instruction[25:21], instruction[15:6]};
  assign w_timeout = L_TIMEOUT_EN && (r_wait_cnt == L_WAIT_LAST);

`ifdef MULDIV_STALL_EN
  logic r_ex_hold;
  logic w_ex_stall;
  assign w_ex_stall = (w_is_muldiv | w_is_mfhilo) & muldiv_busy;
`endif

  assign mem.mem_read  = w_mem_read;
  assign mem.mem_write = w_mem_write;
  assign mem.i_or_d    = w_i_or_d;

  // Instruction classification, legality, branch condition and execute-stage ALU setup.
  always_comb begin
    w_is_rtype  = 1'b0;
    w_is_jr     = 1'b0;
    w_is_muldiv = 1'b0;
    w_is_mfhilo = 1'b0;
    w_is_branch = 1'b0;
    w_is_j      = 1'b0;
    w_is_jal    = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_legal     = 1'b0;
    w_br_cond   = 1'b0;
    w_alu_func  = 6'd0;
    w_alu_src_b = 2'd0;
    case (w_opcode)
      6'h00: begin
        w_is_rtype = 1'b1;
        w_alu_func = w_funct;
        case (w_funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B: w_legal = 1'b1;
          6'h08: begin w_legal = 1'b1; w_is_jr = 1'b1; end
          6'h10, 6'h12: begin w_legal = 1'b1; w_is_mfhilo = 1'b1; end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin w_legal = 1'b1; w_is_muldiv = 1'b1; end
          default: w_legal = 1'b0;
        endcase
      end
      // REGIMM: only BLTZ/BGEZ; the linking forms are not supported
      6'h01: begin
        w_is_branch = 1'b1;
        case (w_rt)
          5'h00: begin w_legal = 1'b1; w_br_cond = rs_sign; end
          5'h01: begin w_legal = 1'b1; w_br_cond = ~rs_sign; end
          default: w_legal = 1'b0;
        endcase
      end
      6'h02: begin w_legal = 1'b1; w_is_j = 1'b1; end
      6'h03: begin w_legal = 1'b1; w_is_jal = 1'b1; end
      6'h04: begin w_legal = 1'b1; w_is_branch = 1'b1; w_alu_func = 6'b100011; w_br_cond = alu_zero; end
      6'h05: begin w_legal = 1'b1; w_is_branch = 1'b1; w_alu_func = 6'b100011; w_br_cond = ~alu_zero; end
      6'h06: begin w_legal = 1'b1; w_is_branch = 1'b1; w_br_cond = rs_sign | rs_zero; end
      6'h07: begin w_legal = 1'b1; w_is_branch = 1'b1; w_br_cond = ~rs_sign & ~rs_zero; end
      6'h09: begin w_legal = 1'b1; w_alu_func = 6'b100001; w_alu_src_b = 2'd1; end
      6'h0A: begin w_legal = 1'b1; w_alu_func = 6'b101010; w_alu_src_b = 2'd1; end
      6'h0B: begin w_legal = 1'b1; w_alu_func = 6'b101011; w_alu_src_b = 2'd1; end
      6'h0C: begin w_legal = 1'b1; w_alu_func = 6'b100100; w_alu_src_b = 2'd2; end
      6'h0D: begin w_legal = 1'b1; w_alu_func = 6'b100101; w_alu_src_b = 2'd2; end
      6'h0E: begin w_legal = 1'b1; w_alu_func = 6'b100110; w_alu_src_b = 2'd2; end
      6'h0F: begin w_legal = 1'b1; w_alu_func = 6'b111111; w_alu_src_b = 2'd1; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        w_legal = 1'b1; w_is_load = 1'b1; w_alu_func = 6'b100001; w_alu_src_b = 2'd1;
      end
      6'h28, 6'h29, 6'h2B: begin
        w_legal = 1'b1; w_is_store = 1'b1; w_alu_func = 6'b100001; w_alu_src_b = 2'd1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Successor of EXECUTE once any mult/div stall has cleared.
  always_comb begin
    if (w_is_load | w_is_store) begin
      w_ex_next = ST_MEMORY;
    end else if (w_is_branch | w_is_j | w_is_jr | w_is_muldiv) begin
      w_ex_next = ST_FETCH;
    end else begin
      w_ex_next = ST_WRITEBACK;
    end
  end

  // Control FSM: state register plus the consecutive wait-request counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
`ifdef MULDIV_STALL_EN
      r_ex_hold  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (pc_zero) begin
            r_state    <= ST_HALT;
            r_wait_cnt <= '0;
          end else if (mem.mem_waitrequest) begin
            if (w_timeout) r_state <= ST_FAULT;
            else           r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
          end else begin
            r_state    <= ST_DECODE;
            r_wait_cnt <= '0;
          end
        end
        ST_DECODE: begin
          r_wait_cnt <= '0;
          r_state    <= w_legal ? ST_EXECUTE : ST_FAULT;
        end
        ST_EXECUTE: begin
          r_wait_cnt <= '0;
`ifdef MULDIV_STALL_EN
          if (w_ex_stall) begin
            r_ex_hold <= 1'b1;
          end else begin
            r_ex_hold <= 1'b0;
            r_state   <= w_ex_next;
          end
`else
          r_state <= w_ex_next;
`endif
        end
        ST_MEMORY: begin
          if (mem.mem_waitrequest) begin
            if (w_timeout) r_state <= ST_FAULT;
            else           r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
          end else begin
            r_state    <= w_is_load ? ST_WRITEBACK : ST_FETCH;
            r_wait_cnt <= '0;
          end
        end
        ST_WRITEBACK: begin
          r_wait_cnt <= '0;
          r_state    <= ST_FETCH;
        end
        ST_HALT:  r_state <= ST_HALT;
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_FAULT;
      endcase
    end
  end

  // Per-state datapath strobes; reset forces every output low regardless of state.
  always_comb begin
    w_mem_read           = 1'b0;
    w_mem_write          = 1'b0;
    w_i_or_d             = 1'b0;
    ir_write             = 1'b0;
    pc_write             = 1'b0;
    pc_source            = 2'd0;
    register_write       = 1'b0;
    memory_to_register   = 1'b0;
    hi_lo_register_write = 1'b0;
    register_destination = 2'd0;
    ALU_src_A            = 1'b0;
    ALU_src_B            = 2'd0;
    ALU_function         = 6'd0;
    active               = 1'b0;
    fault                = 1'b0;
`ifdef MULDIV_STALL_EN
    muldiv_start         = 1'b0;
`endif
    if (reset) begin
      active = 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          active = 1'b1;
          if (pc_zero) begin
            w_mem_read = 1'b0;
          end else begin
            w_mem_read = 1'b1;
            ir_write   = ~mem.mem_waitrequest;
            pc_write   = ~mem.mem_waitrequest;
          end
        end
        ST_DECODE: begin
          active    = 1'b1;
          ALU_src_B = 2'd1;
        end
        ST_EXECUTE: begin
          active       = 1'b1;
          ALU_src_A    = ~w_is_jal;
          ALU_src_B    = w_alu_src_b;
          ALU_function = w_alu_func;
          if (w_is_branch) begin
            pc_write  = w_br_cond;
            pc_source = 2'd1;
          end else if (w_is_j | w_is_jal) begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
          end else if (w_is_jr) begin
            pc_write  = 1'b1;
            pc_source = 2'd3;
          end else if (w_is_muldiv) begin
`ifdef MULDIV_STALL_EN
            hi_lo_register_write = ~muldiv_busy;
            muldiv_start         = ~r_ex_hold;
`else
            hi_lo_register_write = 1'b1;
`endif
          end else begin
            pc_write = 1'b0;
          end
        end
        ST_MEMORY: begin
          active      = 1'b1;
          w_i_or_d    = 1'b1;
          w_mem_read  = w_is_load;
          w_mem_write = w_is_store;
        end
        ST_WRITEBACK: begin
          active             = 1'b1;
          register_write     = 1'b1;
          memory_to_register = w_is_load;
          if (w_is_rtype)    register_destination = 2'd1;
          else if (w_is_jal) register_destination = 2'd2;
          else               register_destination = 2'd0;
        end
        ST_HALT:  active = 1'b0;
        ST_FAULT: fault  = 1'b1;
        default:  fault  = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Cycle-scripted bench: each cycle's expected control word is queued when inputs are driven
// and compared against the DUT mid-cycle.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       register_write;
    logic       memory_to_register;
    logic       hi_lo;
    logic [1:0] reg_dst;
    logic       alu_a;
    logic [1:0] alu_b;
    logic [5:0] alu_f;
    logic       active;
    logic       fault;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'd0;
  logic        pc_zero = 1'b0, alu_zero = 1'b0, rs_sign = 1'b0, rs_zero = 1'b0;
  logic        ir_write, pc_write, register_write, memory_to_register, hi_lo_register_write;
  logic [1:0]  pc_source, register_destination, alu_b;
  logic        alu_a, active, fault;
  logic [5:0]  alu_f;

  logic        s_rst = 1'b1, s_wr = 1'b0, s_pz = 1'b0, s_az = 1'b0, s_sign = 1'b0, s_zero = 1'b0;
  logic [31:0] s_instr = 32'd0;

  int    n_checks = 0;
  int    n_errors = 0;
  out_t  q_exp[$];
  string q_tag[$];
  out_t  w_obs;

  mips_multicycle_controller_if mem_if ();

  mips_multicycle_controller #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .mem                  (mem_if),
    .instruction          (instruction),
    .pc_zero              (pc_zero),
    .alu_zero             (alu_zero),
    .rs_sign              (rs_sign),
    .rs_zero              (rs_zero),
    .ir_write             (ir_write),
    .pc_write             (pc_write),
    .pc_source            (pc_source),
    .register_write       (register_write),
    .memory_to_register   (memory_to_register),
    .hi_lo_register_write (hi_lo_register_write),
    .register_destination (register_destination),
    .ALU_src_A            (alu_a),
    .ALU_src_B            (alu_b),
    .ALU_function         (alu_f),
    .active               (active),
    .fault                (fault)
  );

  assign w_obs = {mem_if.mem_read, mem_if.mem_write, mem_if.i_or_d, ir_write, pc_write, pc_source,
                  register_write, memory_to_register, hi_lo_register_write, register_destination,
                  alu_a, alu_b, alu_f, active, fault};

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic out_t o_zero();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t o_idle();
    out_t o;
    o = '0;
    o.active = 1'b1;
    return o;
  endfunction

  function automatic out_t o_fault();
    out_t o;
    o = '0;
    o.fault = 1'b1;
    return o;
  endfunction

  function automatic out_t o_fetch(input logic wr);
    out_t o;
    o = '0;
    o.active   = 1'b1;
    o.mem_read = 1'b1;
    o.ir_write = ~wr;
    o.pc_write = ~wr;
    return o;
  endfunction

  function automatic out_t o_dec();
    out_t o;
    o = '0;
    o.active = 1'b1;
    o.alu_b  = 2'd1;
    return o;
  endfunction

  function automatic out_t o_ex(input logic a, input logic [1:0] b, input logic [5:0] f,
                                input logic pw, input logic [1:0] ps);
    out_t o;
    o = '0;
    o.active    = 1'b1;
    o.alu_a     = a;
    o.alu_b     = b;
    o.alu_f     = f;
    o.pc_write  = pw;
    o.pc_source = ps;
    return o;
  endfunction

  function automatic out_t o_mem(input logic rd, input logic wr);
    out_t o;
    o = '0;
    o.active    = 1'b1;
    o.i_or_d    = 1'b1;
    o.mem_read  = rd;
    o.mem_write = wr;
    return o;
  endfunction

  function automatic out_t o_wb(input logic [1:0] dst, input logic m2r);
    out_t o;
    o = '0;
    o.active             = 1'b1;
    o.register_write     = 1'b1;
    o.reg_dst            = dst;
    o.memory_to_register = m2r;
    return o;
  endfunction

  // Apply the staged inputs for one cycle and queue the control word they must produce.
  task automatic cyc(input out_t e, input string t);
    @(negedge clk);
    reset                  = s_rst;
    instruction            = s_instr;
    mem_if.mem_waitrequest = s_wr;
    pc_zero                = s_pz;
    alu_zero               = s_az;
    rs_sign                = s_sign;
    rs_zero                = s_zero;
    q_exp.push_back(e);
    q_tag.push_back(t);
  endtask

  task automatic fd(input logic [31:0] instr, input string t);
    s_instr = instr;
    cyc(o_fetch(1'b0), {t, "_f"});
    cyc(o_dec(), {t, "_d"});
  endtask

  initial begin
    out_t  e;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (q_exp.size() != 0) begin
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        check_value(t, 32'(w_obs), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of script");
    $fatal(1, "watchdog expired");
  end

  initial begin
    out_t e;
    mem_if.mem_waitrequest = 1'b0;
    cyc(o_zero(), "rst0");
    cyc(o_zero(), "rst1");
    s_rst = 1'b0;
    // ADDU $3,$1,$2
    fd(32'h00221821, "addu");
    cyc(o_ex(1'b1, 2'd0, 6'b100001, 1'b0, 2'd0), "addu_e");
    cyc(o_wb(2'd1, 1'b0), "addu_w");
    // LW with three wait cycles in MEMORY (one below the timeout)
    fd(32'h8C220004, "lw");
    cyc(o_ex(1'b1, 2'd1, 6'b100001, 1'b0, 2'd0), "lw_e");
    s_wr = 1'b1;
    for (int i = 0; i < 3; i++) cyc(o_mem(1'b1, 1'b0), "lw_mwait");
    s_wr = 1'b0;
    cyc(o_mem(1'b1, 1'b0), "lw_m");
    cyc(o_wb(2'd0, 1'b1), "lw_w");
    // SW
    fd(32'hAC220004, "sw");
    cyc(o_ex(1'b1, 2'd1, 6'b100001, 1'b0, 2'd0), "sw_e");
    cyc(o_mem(1'b0, 1'b1), "sw_m");
    // BEQ taken / not taken
    s_az = 1'b1;
    fd(32'h10220003, "beq1");
    cyc(o_ex(1'b1, 2'd0, 6'b100011, 1'b1, 2'd1), "beq1_e");
    s_az = 1'b0;
    fd(32'h10220003, "beq0");
    cyc(o_ex(1'b1, 2'd0, 6'b100011, 1'b0, 2'd1), "beq0_e");
    // BNE with alu_zero low is taken
    fd(32'h14220003, "bne");
    cyc(o_ex(1'b1, 2'd0, 6'b100011, 1'b1, 2'd1), "bne_e");
    // BLEZ on rs==0, BGTZ on positive and negative rs
    s_zero = 1'b1;
    fd(32'h18200003, "blez");
    cyc(o_ex(1'b1, 2'd0, 6'd0, 1'b1, 2'd1), "blez_e");
    s_zero = 1'b0;
    fd(32'h1C200003, "bgtz1");
    cyc(o_ex(1'b1, 2'd0, 6'd0, 1'b1, 2'd1), "bgtz1_e");
    s_sign = 1'b1;
    fd(32'h1C200003, "bgtz0");
    cyc(o_ex(1'b1, 2'd0, 6'd0, 1'b0, 2'd1), "bgtz0_e");
    fd(32'h04200003, "bltz");
    cyc(o_ex(1'b1, 2'd0, 6'd0, 1'b1, 2'd1), "bltz_e");
    fd(32'h04210003, "bgez");
    cyc(o_ex(1'b1, 2'd0, 6'd0, 1'b0, 2'd1), "bgez_e");
    s_sign = 1'b0;
    // Jumps
    fd(32'h08000010, "j");
    cyc(o_ex(1'b1, 2'd0, 6'd0, 1'b1, 2'd2), "j_e");
    fd(32'h0C000010, "jal");
    cyc(o_ex(1'b0, 2'd0, 6'd0, 1'b1, 2'd2), "jal_e");
    cyc(o_wb(2'd2, 1'b0), "jal_w");
    fd(32'h03E00008, "jr");
    cyc(o_ex(1'b1, 2'd0, 6'h08, 1'b1, 2'd3), "jr_e");
    // MULT: single-cycle HI/LO write then straight back to fetch
    fd(32'h00220018, "mult");
    e = o_ex(1'b1, 2'd0, 6'h18, 1'b0, 2'd0);
    e.hi_lo = 1'b1;
    cyc(e, "mult_e");
    // ORI uses zero-extended immediate
    fd(32'h34220005, "ori");
    cyc(o_ex(1'b1, 2'd2, 6'b100101, 1'b0, 2'd0), "ori_e");
    cyc(o_wb(2'd0, 1'b0), "ori_w");
    // Four consecutive fetch waits hit the timeout
    s_wr = 1'b1;
    for (int i = 0; i < 4; i++) cyc(o_fetch(1'b1), "to_fwait");
    s_wr = 1'b0;
    cyc(o_fault(), "to_fault0");
    cyc(o_fault(), "to_fault1");
    // Reset leaves FAULT; illegal opcode 0x3F faults from DECODE
    s_rst = 1'b1;
    cyc(o_zero(), "rst_fault");
    s_rst = 1'b0;
    fd(32'hFC000000, "ill");
    cyc(o_fault(), "ill_fault");
    s_rst = 1'b1;
    cyc(o_zero(), "rst_ill");
    s_rst = 1'b0;
    // BLTZAL is not supported
    fd(32'h04300003, "bltzal");
    cyc(o_fault(), "bltzal_fault");
    s_rst = 1'b1;
    cyc(o_zero(), "rst_bltzal");
    s_rst = 1'b0;
    // Reset mid-store while memory stalls
    fd(32'hAC220004, "swr");
    cyc(o_ex(1'b1, 2'd1, 6'b100001, 1'b0, 2'd0), "swr_e");
    s_wr = 1'b1;
    cyc(o_mem(1'b0, 1'b1), "swr_m");
    s_rst = 1'b1;
    cyc(o_zero(), "swr_rst");
    s_rst = 1'b0;
    s_wr  = 1'b0;
    cyc(o_fetch(1'b0), "swr_refetch");
    cyc(o_dec(), "swr_redecode");
    cyc(o_ex(1'b1, 2'd1, 6'b100001, 1'b0, 2'd0), "swr_reexec");
    cyc(o_mem(1'b0, 1'b1), "swr_rem");
    // PC zero halts; HALT is absorbing until reset
    s_pz = 1'b1;
    cyc(o_idle(), "halt_f");
    s_pz = 1'b0;
    for (int i = 0; i < 3; i++) cyc(o_zero(), "halt_hold");
    s_rst = 1'b1;
    cyc(o_zero(), "rst_halt");
    s_rst = 1'b0;
    fd(32'h00221821, "post_halt");
    @(negedge clk);
    @(negedge clk);
    check_value("queue_drain", 32'(q_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
